// File: rtl/ym3438_ch_accum.sv
`default_nettype none
// ============================================================================
// Module   : ym3438_ch_accum
// Purpose  : Per-channel operator output accumulator with output saturation.
//            Optional channel-6 DAC override: YM3438_CH_ACCUM_DAC_EN.
// Revision : 1.0  initial release
// ============================================================================
module ym3438_ch_accum #(
    parameter int OP_W  = 14,
    parameter int ACC_W = 17,
    parameter int OUT_W = 14
) (
    input  logic                    MCLK,
    input  logic                    reset,
    input  logic                    c1,
    input  logic                    fsm_sel0,
    input  logic                    alg_out,
    input  logic signed [OP_W-1:0]  op_out,
    input  logic                    dac_en,
    input  logic [8:0]              dac_data,
    output logic                    ch_out_valid,
    output logic [2:0]              ch_out_idx,
    output logic [OUT_W-1:0]        ch_out_data,
    output logic                    frame_done
);

    localparam logic [4:0] c_LAST_SLOT = 5'd23;
    localparam logic [2:0] c_LAST_CH   = 3'd5;
    localparam logic [1:0] c_GRP_OP4   = 2'd0;
    localparam logic [1:0] c_GRP_OP1   = 2'd1;
    localparam logic signed [ACC_W-1:0] c_OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Slot counter plus a channel/group pair tracked alongside it so the
    // mod-6 / div-6 decode never needs a divider.
    logic [4:0]              r_slot;
    logic [2:0]              r_ch;
    logic [1:0]              r_grp;
    logic signed [ACC_W-1:0] r_acc [6];
    logic [5:0]              r_primed;

    logic                    r_valid;
    logic [2:0]              r_idx;
    logic [OUT_W-1:0]        r_data;
    logic                    r_frame_done;

    logic [4:0]              w_slot;
    logic [2:0]              w_ch;
    logic [1:0]              w_grp;
    logic [4:0]              w_slot_next;
    logic [2:0]              w_ch_next;
    logic [1:0]              w_grp_next;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_sum;
    logic [OUT_W-1:0]        w_clamped;
    logic                    w_dac_sel;
    logic [OUT_W-1:0]        w_final;
    logic                    w_emit;

    // A slot-0 marker overrides the counter for the strobe it arrives on.
    assign w_slot = fsm_sel0 ? 5'd0 : r_slot;
    assign w_ch   = fsm_sel0 ? 3'd0 : r_ch;
    assign w_grp  = fsm_sel0 ? 2'd0 : r_grp;

    assign w_slot_next = (w_slot == c_LAST_SLOT) ? 5'd0 : w_slot + 5'd1;
    assign w_ch_next   = (w_ch == c_LAST_CH) ? 3'd0 : w_ch + 3'd1;
    assign w_grp_next  = (w_ch == c_LAST_CH) ? w_grp + 2'd1 : w_grp;

    assign w_term = alg_out ? {{(ACC_W-OP_W){op_out[OP_W-1]}}, op_out}
                            : {ACC_W{1'b0}};
    assign w_sum  = r_acc[w_ch] + w_term;

    always_comb begin
        w_clamped = w_sum[OUT_W-1:0];
        if (w_sum > c_OUT_MAX) begin
            w_clamped = c_OUT_MAX[OUT_W-1:0];
        end else if (w_sum < c_OUT_MIN) begin
            w_clamped = c_OUT_MIN[OUT_W-1:0];
        end
    end

`ifdef YM3438_CH_ACCUM_DAC_EN
    // Offset-binary to two's complement is a flip of the MSB.
    logic [13:0]      w_dac_word;
    logic [OUT_W-1:0] w_dac_out;

    assign w_dac_word = {~dac_data[8], dac_data[7:0], 5'b0};
    assign w_dac_sel  = dac_en && (w_ch == c_LAST_CH);

    generate
        if (OUT_W > 14) begin : g_dac_ext
            assign w_dac_out = {{(OUT_W-14){w_dac_word[13]}}, w_dac_word};
        end else if (OUT_W == 14) begin : g_dac_eq
            assign w_dac_out = w_dac_word;
        end else begin : g_dac_trunc
            assign w_dac_out = w_dac_word[OUT_W-1:0];
        end
    endgenerate

    assign w_final = w_dac_sel ? w_dac_out : w_clamped;
`else
    logic w_unused_dac;

    assign w_unused_dac = ^{dac_en, dac_data};
    assign w_dac_sel    = 1'b0;
    assign w_final      = w_clamped;
`endif

    assign w_emit = (w_grp == c_GRP_OP4) && (r_primed[w_ch] || w_dac_sel);

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_slot       <= 5'd0;
            r_ch         <= 3'd0;
            r_grp        <= 2'd0;
            r_primed     <= 6'd0;
            for (int i = 0; i < 6; i++) begin
                r_acc[i] <= {ACC_W{1'b0}};
            end
            r_valid      <= 1'b0;
            r_idx        <= 3'd0;
            r_data       <= {OUT_W{1'b0}};
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            if (c1) begin
                r_slot <= w_slot_next;
                r_ch   <= w_ch_next;
                r_grp  <= w_grp_next;
                if (w_grp == c_GRP_OP1) begin
                    r_acc[w_ch]    <= w_term;
                    r_primed[w_ch] <= 1'b1;
                end else if (w_grp != c_GRP_OP4) begin
                    r_acc[w_ch] <= w_sum;
                end else if (w_emit) begin
                    r_valid      <= 1'b1;
                    r_idx        <= w_ch;
                    r_data       <= w_final;
                    r_frame_done <= (w_ch == c_LAST_CH);
                end
            end
        end
    end

    assign ch_out_valid = r_valid;
    assign ch_out_idx   = r_idx;
    assign ch_out_data  = r_data;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ym3438_ch_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_ym3438_ch_accum
// Purpose  : Self-checking bench for ym3438_ch_accum against a slot-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ym3438_ch_accum;

    localparam int c_OUT_W  = 14;
    localparam int c_OMAX   = (1 << (c_OUT_W - 1)) - 1;
    localparam int c_OMIN   = -(1 << (c_OUT_W - 1));
    localparam int c_NOCHK  = 99999;

    logic        MCLK = 1'b0;
    logic        reset;
    logic        c1;
    logic        fsm_sel0;
    logic        alg_out;
    logic [13:0] op_out;
    logic        dac_en;
    logic [8:0]  dac_data;
    logic        ch_out_valid;
    logic [2:0]  ch_out_idx;
    logic [13:0] ch_out_data;
    logic        frame_done;

    ym3438_ch_accum dut (
        .MCLK         (MCLK),
        .reset        (reset),
        .c1           (c1),
        .fsm_sel0     (fsm_sel0),
        .alg_out      (alg_out),
        .op_out       (op_out),
        .dac_en       (dac_en),
        .dac_data     (dac_data),
        .ch_out_valid (ch_out_valid),
        .ch_out_idx   (ch_out_idx),
        .ch_out_data  (ch_out_data),
        .frame_done   (frame_done)
    );

    always #5 MCLK = ~MCLK;

    int n_check = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: slot-level arithmetic on plain integers.
    int m_cnt;
    int m_acc [6];
    bit m_primed [6];
    int e_valid, e_idx, e_data, e_fd;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, ch_out_valid}, e_valid);
        check({tag, "_idx"},   {29'b0, ch_out_idx},   e_idx);
        check({tag, "_data"},  $signed(ch_out_data),  e_data);
        check({tag, "_fdone"}, {31'b0, frame_done},   e_fd);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            m_acc[i]    = 0;
            m_primed[i] = 1'b0;
        end
        e_valid = 0; e_idx = 0; e_data = 0; e_fd = 0;
    endtask

    task automatic model_step(input bit sel0, input bit alg, input int op);
        int slot, ch, grp, t, sum;
        bit dac;
        slot  = sel0 ? 0 : m_cnt;
        m_cnt = (slot == 23) ? 0 : slot + 1;
        ch    = slot % 6;
        grp   = slot / 6;
        t     = alg ? op : 0;
        e_valid = 0;
        e_fd    = 0;
        if (grp == 1) begin
            m_acc[ch]    = t;
            m_primed[ch] = 1'b1;
        end else if (grp >= 2) begin
            m_acc[ch] += t;
        end else begin
            sum = m_acc[ch] + t;
            dac = 1'b0;
`ifdef YM3438_CH_ACCUM_DAC_EN
            dac = dac_en && (ch == 5);
`endif
            if (m_primed[ch] || dac) begin
                e_valid = 1;
                e_idx   = ch;
                e_fd    = (ch == 5) ? 1 : 0;
                if (dac) e_data = (int'(dac_data) - 256) * 32;
                else if (sum > c_OMAX) e_data = c_OMAX;
                else if (sum < c_OMIN) e_data = c_OMIN;
                else e_data = sum;
            end
        end
    endtask

    task automatic strobe(input bit sel0, input bit alg, input int op, input string tag);
        logic [31:0] opv;
        opv = op;
        @(negedge MCLK);
        c1       = 1'b1;
        fsm_sel0 = sel0;
        alg_out  = alg;
        op_out   = opv[13:0];
        @(posedge MCLK);
        #1;
        model_step(sel0, alg, op);
        check_outputs(tag);
    endtask

    task automatic idle();
        logic [31:0] r;
        r = $urandom;
        @(negedge MCLK);
        c1       = 1'b0;
        fsm_sel0 = r[0];
        alg_out  = r[1];
        op_out   = r[15:2];
        @(posedge MCLK);
        #1;
        e_valid = 0;
        e_fd    = 0;
        check_outputs("idle");
    endtask

    // kind: 0 = all 100, 1 = +max, 2 = -max, 3 = op4-only mask, 4 = random
    task automatic frame(input int kind, input int exp_lo, input int exp_ch5);
        bit alg;
        int op;
        for (int s = 0; s < 24; s++) begin
            alg = 1'b1;
            case (kind)
                0: op = 100;
                1: op = 8191;
                2: op = -8192;
                3: begin
                    alg = (s < 6);
                    op  = alg ? 50 : 1000;
                end
                default: begin
                    alg = 1'($urandom_range(0, 1));
                    op  = int'($urandom_range(0, 16383)) - 8192;
                end
            endcase
            strobe(s == 0, alg, op, "frame");
            if (s < 5 && exp_lo != c_NOCHK) begin
                check("const_data", $signed(ch_out_data), exp_lo);
                check("const_valid", {31'b0, ch_out_valid}, 1);
            end
            if (s == 5 && exp_ch5 != c_NOCHK) begin
                check("ch5_data", $signed(ch_out_data), exp_ch5);
                check("ch5_fdone", {31'b0, frame_done}, 1);
                check("ch5_idx", {29'b0, ch_out_idx}, 5);
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
    endtask

    initial begin
        reset    = 1'b1;
        c1       = 1'b0;
        fsm_sel0 = 1'b0;
        alg_out  = 1'b0;
        op_out   = 14'd0;
        dac_en   = 1'b0;
        dac_data = 9'd0;
        model_reset();
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_valid", {31'b0, ch_out_valid}, 0);
        check("rst_idx",   {29'b0, ch_out_idx},   0);
        check("rst_data",  $signed(ch_out_data),  0);
        check("rst_fdone", {31'b0, frame_done},   0);
        @(negedge MCLK);
        reset = 1'b0;

        // Unprimed first frame, then the 4 x 100 steady state.
        frame(0, c_NOCHK, c_NOCHK);
        frame(0, 400, 400);

        // Saturation: the second frame of each sees four equal terms.
        frame(1, c_NOCHK, c_NOCHK);
        frame(1, 8191, 8191);
        frame(2, c_NOCHK, c_NOCHK);
        frame(2, -8192, -8192);

        // Algorithm mask: only op4 reaches the output.
        frame(3, c_NOCHK, c_NOCHK);
        frame(3, 50, 50);

        for (int f = 0; f < 4; f++) begin
            dac_data = 9'($urandom);
            frame(4, c_NOCHK, c_NOCHK);
        end
        dac_data = 9'd0;

        // Asynchronous reset in slot 14 of a primed frame.
        frame(0, c_NOCHK, c_NOCHK);
        frame(0, 400, 400);
        for (int s = 0; s < 14; s++) strobe(s == 0, 1'b1, 100, "pre_rst");
        #3;
        c1    = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_valid", {31'b0, ch_out_valid}, 0);
        check("mid_rst_idx",   {29'b0, ch_out_idx},   0);
        check("mid_rst_data",  $signed(ch_out_data),  0);
        check("mid_rst_fdone", {31'b0, frame_done},   0);
        @(negedge MCLK);
        reset = 1'b0;
        for (int s = 0; s < 6; s++) begin
            strobe(s == 0, 1'b1, 100, "post_rst");
            check("post_rst_silent", {31'b0, ch_out_valid}, 0);
        end
        for (int s = 6; s < 24; s++) strobe(1'b0, 1'b1, 100, "post_rst");
        frame(0, 400, 400);

        // Resync: slot marker arrives with the counter at 10.
        for (int s = 0; s < 10; s++) strobe(s == 0, 1'b1, 100, "pre_sync");
        strobe(1'b1, 1'b1, 100, "sync");
        check("sync_idx0", {29'b0, ch_out_idx}, 0);
        check("sync_valid0", {31'b0, ch_out_valid}, 1);
        strobe(1'b0, 1'b1, 100, "sync");
        check("sync_idx1", {29'b0, ch_out_idx}, 1);
        for (int s = 2; s < 24; s++) strobe(1'b0, 1'b1, 100, "post_sync");
        frame(0, 400, 400);

        // DAC override on channel 5.
        dac_en   = 1'b1;
        dac_data = 9'h1FF;
`ifdef YM3438_CH_ACCUM_DAC_EN
        frame(0, 400, 8160);
`else
        frame(0, 400, 400);
`endif
        dac_en   = 1'b0;
        dac_data = 9'd0;
        frame(4, c_NOCHK, c_NOCHK);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ym3438_ch_accum.md
# ym3438_ch_accum

Channel output accumulator for the YM3438 core. It sits directly downstream of the slot/algorithm sequencer and the operator output stage. Each sample frame it sums the operator outputs that the current algorithm routes to the channel output, one operator slot at a time. It then clamps the completed sum for each of the six channels and presents it as a registered channel sample.

## Interface

Parameters
- OP_W, default 14: operator output width, signed.
- ACC_W, default 17: accumulator width, signed.
- OUT_W, default 14: channel output width, signed, saturated.

Ports
- MCLK, input, 1: master clock. Single clock domain.
- reset, input, 1: asynchronous, active-high. Clears all state.
- c1, input, 1: slot strobe. All state advances only on MCLK edges where c1=1.
- fsm_sel0, input, 1: high during slot 0; resynchronises the slot counter.
- alg_out, input, 1: the current slot's operator contributes to the channel output.
- op_out, input, OP_W: operator output for the current slot, signed.
- dac_en, input, 1: channel 6 DAC override enable (see Configuration).
- dac_data, input, 9: DAC override sample, unsigned offset-binary.
- ch_out_valid, output, 1: one-MCLK pulse; a new channel sample has been written.
- ch_out_idx, output, 3: channel index 0–5 of the last written sample.
- ch_out_data, output, OUT_W: last written channel sample, signed.
- frame_done, output, 1: one-MCLK pulse, coincident with the channel-5 write.

## Operation

- Slot counter: 5-bit, range 0..23, wraps 23→0.
  - Increments on each c1 strobe.
  - If fsm_sel0=1 at a strobe, the counter loads 1. Slot 0 is processed as slot 0.
- Channel and group decode: ch = slot mod 6; grp = slot div 6.
  - grp 0 = op4.
  - grp 1 = op1.
  - grp 2 = op3.
  - grp 3 = op2.
- Contribution term: t = alg_out ? sign_extend(op_out) : 0.
- Per-strobe action on acc[ch], by group:
  - grp 1 (op1): acc[ch] ← t; primed[ch] ← 1. This starts the frame's sum.
  - grp 2, grp 3: acc[ch] ← acc[ch] + t.
  - grp 0 (op4): sum = acc[ch] + t. If primed[ch]=1:
    - ch_out_data ← clamp(sum) to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - ch_out_idx ← ch.
    - ch_out_valid pulses.
    - frame_done pulses if ch=5.
  - If primed[ch]=0, no output is produced and no pulse is generated.
- Arithmetic width: ACC_W=17 holds four full-scale 14-bit terms without overflow. The only range reduction is the final clamp.
- Other outputs hold their value between writes.

## Timing

- op_out and alg_out are sampled on the MCLK edge where c1=1.
- The result is visible on the same edge. ch_out_* update on that edge.
- ch_out_valid is high for exactly the following MCLK cycle.
- Latency from an op4-group sample to output: 1 MCLK.
- Frame: 24 strobes. One channel sample is produced per strobe in slots 0–5.
- Boundary conditions:
  - Reset asserted mid-frame: all acc, primed, counter and outputs go to 0 immediately. After release, channels are silent until their next grp 1 slot.
  - fsm_sel0 at an unexpected slot: the counter resyncs and in-flight sums continue on the new decode. No error flag is raised.
  - Strobe with c1=0: no state change.
  - Wrap 23→0: a grp 3 accumulate followed by a grp 0 finalise is normal flow.
- Reset values:
  - ch_out_valid = 0.
  - ch_out_idx = 0.
  - ch_out_data = 0.
  - frame_done = 0.
  - counter = 0.
  - primed = 0.

## Configuration

- YM3438_CH_ACCUM_DAC_EN defined:
  - When dac_en=1, the channel-5 finalise writes ch_out_data ← {dac_data − 256, 5'b0}, truncated to OUT_W, instead of the sum.
  - primed is ignored for channel 5 in that case.
  - Channel-5 accumulation still runs.
- Not defined: dac_en and dac_data are ignored. Channel 5 behaves like every other channel.

## Test plan

- Reset, then 2 frames with alg_out=1 and op_out=100 on every slot → first frame: no valid pulses in slots 0–5. Second frame: each channel outputs 400, and frame_done pulses with idx=5.
- Saturation: op_out=8191 on all four groups with alg_out=1 → ch_out_data=8191. With op_out=-8192 → -8192.
- Algorithm mask: alg_out=1 only in grp 0, op_out=50, other groups 1000 → output 50.
- Reset asserted at slot 14 of a primed frame → outputs 0 immediately. The next slots 0–5 produce no pulse.
- fsm_sel0 forced at counter=10 → the next strobe treats the slot as 1. The output channel index sequence restarts correctly.
- Macro defined, dac_en=1, dac_data=0x1FF → ch5 output = 255<<5 = 8160, truncated. Macro undefined → ch5 output is the normal sum.
